key_debounce_array: RTL and testbench

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

---
 rtl/key_debounce_array.sv | 96 +++++++++
 tb/tb_key_debounce_array.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// Multi-channel push-button conditioner: synchronises each raw input, debounces it,
// and derives registered press / release / long-press pulses per channel.
module key_debounce_array #(
   parameter int N             = 4,
   parameter int STABLE_CYCLES = 10,
   parameter int LONG_CYCLES   = 1000,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] btn_in,
   output logic [N-1:0] btn_stable,
   output logic [N-1:0] btn_press,
   output logic [N-1:0] btn_release,
   output logic [N-1:0] btn_long,
   output logic         any_press
);

   localparam int DW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam int HW = (LONG_CYCLES < 1) ? 1 : $clog2(LONG_CYCLES + 1);
   localparam logic          AL        = (ACTIVE_LOW != 0);
   localparam logic [DW-1:0] DB_LAST   = DW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   logic [N-1:0]  sync_q1;
   logic [N-1:0]  sync_q2;
   logic [N-1:0]  sample;
   logic [N-1:0]  accept;
   logic [DW-1:0] db_cnt   [N];
   logic [HW-1:0] hold_cnt [N];

   // Synchroniser resets to the idle raw level so reset itself never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= {N{AL}};
         sync_q2 <= {N{AL}};
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
      end
   end

   assign sample = sync_q2 ^ {N{AL}};

   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < N; i++) begin
         accept[i] = (sample[i] != btn_stable[i]) && (db_cnt[i] == DB_LAST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_stable  <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         btn_stable  <= btn_stable ^ accept;
         btn_press   <= accept & sample;
         btn_release <= accept & ~sample;
         for (int unsigned i = 0; i < N; i++) begin
            if ((sample[i] == btn_stable[i]) || accept[i]) begin
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Saturating hold counter fires the long pulse once; a release on that same edge wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_long <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            hold_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!btn_stable[i]) begin
               hold_cnt[i] <= '0;
            end else if (hold_cnt[i] != HOLD_MAX) begin
               hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
            btn_long[i] <= btn_stable[i] && !accept[i] && (hold_cnt[i] == HOLD_LAST);
         end
      end
   end

   assign any_press = |btn_press;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: an active-high and an active-low instance checked
// against a sliding-window reference model plus directed timing checks.
module tb_key_debounce_array;

   localparam int N  = 4;
   localparam int ST = 10;
   localparam int LG = 50;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn_a = '0;
   logic [N-1:0] btn_b = '1;
   logic [N-1:0] a_stable, a_press, a_rel, a_long;
   logic [N-1:0] b_stable, b_press, b_rel, b_long;
   logic         a_any, b_any;
   logic [4*N:0] obs_a, obs_b;

   int vectors    = 0;
   int miscompares = 0;
   int edge_no    = 0;

   always #5 clk = ~clk;

   key_debounce_array #(.N(N), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .ACTIVE_LOW(0)) dut_a (
      .clk(clk), .rst(rst), .btn_in(btn_a), .btn_stable(a_stable), .btn_press(a_press),
      .btn_release(a_rel), .btn_long(a_long), .any_press(a_any));

   key_debounce_array #(.N(N), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .ACTIVE_LOW(1)) dut_b (
      .clk(clk), .rst(rst), .btn_in(btn_b), .btn_stable(b_stable), .btn_press(b_press),
      .btn_release(b_rel), .btn_long(b_long), .any_press(b_any));

   assign obs_a = {a_stable, a_press, a_rel, a_long, a_any};
   assign obs_b = {b_stable, b_press, b_rel, b_long, b_any};

   // Reference: a level is accepted once the last ST synchronised samples all disagree with it.
   logic [N-1:0] m_hist [2][ST+2];
   logic [N-1:0] m_stable [2];
   logic [N-1:0] m_press  [2];
   logic [N-1:0] m_rel    [2];
   logic [N-1:0] m_long   [2];
   int           m_pedge  [2][N];

   function automatic void model_reset(int d);
      for (int k = 0; k < ST + 2; k++) m_hist[d][k] = '0;
      m_stable[d] = '0;
      m_press[d]  = '0;
      m_rel[d]    = '0;
      m_long[d]   = '0;
      for (int c = 0; c < N; c++) m_pedge[d][c] = -1000000;
   endfunction

   function automatic void model_edge(int d, logic [N-1:0] raw, logic al);
      logic [N-1:0] norm;
      logic         all_diff;
      norm = raw ^ {N{al}};
      for (int k = ST + 1; k >= 1; k--) m_hist[d][k] = m_hist[d][k-1];
      m_hist[d][0] = norm;
      m_press[d] = '0;
      m_rel[d]   = '0;
      m_long[d]  = '0;
      for (int c = 0; c < N; c++) begin
         all_diff = 1'b1;
         for (int k = 2; k < ST + 2; k++) begin
            if (m_hist[d][k][c] == m_stable[d][c]) all_diff = 1'b0;
         end
         if (all_diff) begin
            m_stable[d][c] = ~m_stable[d][c];
            if (m_stable[d][c]) begin
               m_press[d][c] = 1'b1;
               m_pedge[d][c] = edge_no;
            end else begin
               m_rel[d][c] = 1'b1;
            end
         end else if (m_stable[d][c] && (edge_no == m_pedge[d][c] + LG)) begin
            m_long[d][c] = 1'b1;
         end
      end
   endfunction

   function automatic logic [4*N:0] exp_vec(int d);
      return {m_stable[d], m_press[d], m_rel[d], m_long[d], |m_press[d]};
   endfunction

   task automatic tick();
      logic [N-1:0] ra, rb;
      ra = btn_a;
      rb = btn_b;
      @(posedge clk);
      edge_no++;
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_edge(0, ra, 1'b0);
         model_edge(1, rb, 1'b1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_a = '0; btn_b = '1;
      repeat (3) tick();
      vectors++;
      if (obs_a !== '0) begin miscompares++; $display("FAIL reset_a: got %h want 0", obs_a); end
      vectors++;
      if (obs_b !== '0) begin miscompares++; $display("FAIL reset_b: got %h want 0", obs_b); end
      rst = 1'b0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         vectors++;
         if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL reset_model_a t=%0d: got %h want %h", t, obs_a, exp_vec(0)); end
         vectors++;
         if (obs_b !== '0) begin miscompares++; $display("FAIL idle_active_low t=%0d: got %h want 0", t, obs_b); end
      end
   endtask

   task automatic test_single_press();
      btn_a[0] = 1'b1;
      for (int t = 1; t <= 16; t++) begin
         tick();
         vectors++;
         if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL press_model t=%0d: got %h want %h", t, obs_a, exp_vec(0)); end
         vectors++;
         if (a_stable[0] !== (t >= 12) || a_press[0] !== (t == 12) || a_any !== (t == 12))
            begin miscompares++; $display("FAIL press_edge12 t=%0d: got s=%b p=%b any=%b want s=%b p=%b", t, a_stable[0], a_press[0], a_any, t >= 12, t == 12); end
      end
   endtask

   task automatic test_bounce();
      int npress = 0;
      int ptick  = -1;
      logic stable_moved = 1'b0;
      for (int c = 0; c < 60; c++) begin
         btn_a[1] = (c < 40) ? (((c / 3) % 2) == 0) : 1'b1;
         tick();
         vectors++;
         if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL bounce_model t=%0d: got %h want %h", c + 1, obs_a, exp_vec(0)); end
         if (a_press[1]) begin npress++; ptick = c + 1; end
         if (c + 1 < 52 && a_stable[1]) stable_moved = 1'b1;
      end
      vectors++;
      if (npress != 1 || ptick != 52 || stable_moved)
         begin miscompares++; $display("FAIL bounce_press: got count=%0d tick=%0d early=%b want count=1 tick=52 early=0", npress, ptick, stable_moved); end
   endtask

   task automatic test_long();
      int ptick = -1, ltick = -1, nlong = 0, rtick = -1;
      btn_a[2] = 1'b1;
      for (int t = 1; t <= 100; t++) begin
         tick();
         vectors++;
         if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL long_model t=%0d: got %h want %h", t, obs_a, exp_vec(0)); end
         if (a_press[2]) ptick = t;
         if (a_long[2]) begin nlong++; ltick = t; end
         vectors++;
         if ((a_press[2] + a_rel[2] + a_long[2]) > 1) begin miscompares++; $display("FAIL long_exclusive t=%0d: got p=%b r=%b l=%b want at most one", t, a_press[2], a_rel[2], a_long[2]); end
      end
      vectors++;
      if (ptick != 12 || ltick != 62 || nlong != 1)
         begin miscompares++; $display("FAIL long_pulse: got press=%0d long=%0d count=%0d want 12 62 1", ptick, ltick, nlong); end
      btn_a[2] = 1'b0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (a_rel[2]) rtick = t;
      end
      vectors++;
      if (rtick != 12) begin miscompares++; $display("FAIL long_release: got tick=%0d want 12", rtick); end
      nlong = 0; rtick = -1;
      btn_a[2] = 1'b1;
      for (int t = 1; t <= 100; t++) begin
         if (t == 31) btn_a[2] = 1'b0;
         tick();
         vectors++;
         if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL short_model t=%0d: got %h want %h", t, obs_a, exp_vec(0)); end
         if (a_long[2]) nlong++;
         if (a_rel[2]) rtick = t;
      end
      vectors++;
      if (nlong != 0 || rtick != 42)
         begin miscompares++; $display("FAIL short_hold: got long=%0d release=%0d want 0 42", nlong, rtick); end
   endtask

   task automatic test_active_low();
      btn_b[3] = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         tick();
         vectors++;
         if (obs_b !== exp_vec(1)) begin miscompares++; $display("FAIL al_model t=%0d: got %h want %h", t, obs_b, exp_vec(1)); end
         vectors++;
         if (b_press[3] !== (t == 12) || b_stable[3] !== (t >= 12))
            begin miscompares++; $display("FAIL al_press t=%0d: got p=%b s=%b want p=%b s=%b", t, b_press[3], b_stable[3], t == 12, t >= 12); end
      end
      btn_b[3] = 1'b1;
      for (int t = 1; t <= 14; t++) begin
         tick();
         vectors++;
         if (b_rel[3] !== (t == 12)) begin miscompares++; $display("FAIL al_release t=%0d: got %b want %b", t, b_rel[3], t == 12); end
      end
   endtask

   task automatic test_simultaneous();
      btn_a = '0;
      repeat (15) tick();
      btn_a = 4'b1001;
      for (int t = 1; t <= 14; t++) begin
         tick();
         vectors++;
         if (a_press !== ((t == 12) ? 4'b1001 : 4'b0000) || a_any !== (t == 12))
            begin miscompares++; $display("FAIL simul_press t=%0d: got p=%b any=%b want p=%b", t, a_press, a_any, (t == 12) ? 4'b1001 : 4'b0000); end
      end
      btn_a = '0;
      repeat (15) tick();
      for (int pass = 0; pass < 2; pass++) begin
         btn_a = 4'b0010;
         repeat (5) tick();
         rst = 1'b1;
         #1;
         model_reset(0); model_reset(1);
         vectors++;
         if (obs_a !== '0 || obs_b !== '0) begin miscompares++; $display("FAIL reset_abort pass=%0d: got a=%h b=%h want 0", pass, obs_a, obs_b); end
         repeat (3) tick();
         if (pass == 0) btn_a = '0;
         rst = 1'b0;
         for (int t = 1; t <= 20; t++) begin
            tick();
            vectors++;
            if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL reset_model pass=%0d t=%0d: got %h want %h", pass, t, obs_a, exp_vec(0)); end
            vectors++;
            if (a_press[1] !== (pass == 1 && t == 12))
               begin miscompares++; $display("FAIL after_reset pass=%0d t=%0d: got %b want %b", pass, t, a_press[1], pass == 1 && t == 12); end
         end
      end
   endtask

   task automatic test_random();
      int hold_a [N];
      int hold_b [N];
      for (int c = 0; c < N; c++) begin
         hold_a[c] = $urandom_range(1, 90);
         hold_b[c] = $urandom_range(1, 90);
      end
      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < N; c++) begin
            if (--hold_a[c] <= 0) begin btn_a[c] = ~btn_a[c]; hold_a[c] = $urandom_range(1, 90); end
            if (--hold_b[c] <= 0) begin btn_b[c] = ~btn_b[c]; hold_b[c] = $urandom_range(1, 90); end
         end
         if ($urandom_range(0, 599) == 0) begin
            rst = 1'b1;
            #1;
            model_reset(0); model_reset(1);
            vectors++;
            if (obs_a !== '0 || obs_b !== '0) begin miscompares++; $display("FAIL rand_reset t=%0d: got a=%h b=%h want 0", t, obs_a, obs_b); end
            tick();
            tick();
            rst = 1'b0;
         end
         tick();
         vectors++;
         if (obs_a !== exp_vec(0)) begin miscompares++; $display("FAIL rand_a t=%0d: got %h want %h", t, obs_a, exp_vec(0)); end
         vectors++;
         if (obs_b !== exp_vec(1)) begin miscompares++; $display("FAIL rand_b t=%0d: got %h want %h", t, obs_b, exp_vec(1)); end
         vectors++;
         if (((a_press & a_rel) | (a_press & a_long) | (a_rel & a_long)) !== '0)
            begin miscompares++; $display("FAIL rand_exclusive t=%0d: got p=%b r=%b l=%b want disjoint", t, a_press, a_rel, a_long); end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_long();
      test_active_low();
      test_simultaneous();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
